// File: rtl/alu_resp_collector.sv
// Collects ALU result beats into a 16-bit MISR signature and compares it with an expected value.
// Reports pass, fail or idle timeout to the self-test controller.
module alu_resp_collector #(
   parameter logic [15:0] SEED    = 16'hFFFF,
   parameter logic [15:0] POLY    = 16'h1021,
   parameter int          TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  num_beats,
   input  logic [15:0] exp_sig,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_res,
   input  logic        in_carry,
   input  logic [3:0]  in_sel,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout_err,
   output logic [15:0] signature,
   output logic [7:0]  beat_cnt,
   output logic [7:0]  carry_cnt
);

   localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE, S_ERR} state_t;

   state_t           state_q, state_d;
   logic [7:0]       nbeats_q, nbeats_d;
   logic [15:0]      exp_q, exp_d;
   logic [15:0]      sig_q, sig_d;
   logic [7:0]       beat_q, beat_d;
   logic [7:0]       carry_q, carry_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             pass_q, pass_d;
   logic [15:0]      sig_next;

   assign sig_next = ({sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000))
                     ^ {3'b000, in_sel, in_carry, in_res};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         nbeats_q <= 8'd0;
         exp_q    <= 16'h0000;
         sig_q    <= SEED;
         beat_q   <= 8'd0;
         carry_q  <= 8'd0;
         timer_q  <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         nbeats_q <= nbeats_d;
         exp_q    <= exp_d;
         sig_q    <= sig_d;
         beat_q   <= beat_d;
         carry_q  <= carry_d;
         timer_q  <= timer_d;
         pass_q   <= pass_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      nbeats_d = nbeats_q;
      exp_d    = exp_q;
      sig_d    = sig_q;
      beat_d   = beat_q;
      carry_d  = carry_q;
      timer_d  = timer_q;
      pass_d   = pass_q;
      // start wins in every state; a beat offered alongside a restart is dropped
      if (start) begin
         nbeats_d = num_beats;
         exp_d    = exp_sig;
         sig_d    = SEED;
         beat_d   = 8'd0;
         carry_d  = 8'd0;
         timer_d  = '0;
         pass_d   = 1'b0;
         if (num_beats == 8'd0) begin
            state_d = S_DONE;
            pass_d  = (SEED == exp_sig);
         end else begin
            state_d = S_COLLECT;
         end
      end else if (state_q == S_COLLECT) begin
         if (in_valid) begin
            sig_d   = sig_next;
            beat_d  = beat_q + 8'd1;
            carry_d = (in_carry && carry_q != 8'hFF) ? carry_q + 8'd1 : carry_q;
            timer_d = '0;
            if (beat_q == nbeats_q - 8'd1) begin
               state_d = S_DONE;
               pass_d  = (sig_next == exp_q);
            end
         end else if (timer_q == TMR_LAST) begin
            state_d = S_ERR;
            pass_d  = 1'b0;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end
   end

   assign in_ready    = (state_q == S_COLLECT);
   assign busy        = (state_q == S_COLLECT);
   assign done        = (state_q == S_DONE) || (state_q == S_ERR);
   assign timeout_err = (state_q == S_ERR);
   assign pass        = pass_q;
   assign signature   = sig_q;
   assign beat_cnt    = beat_q;
   assign carry_cnt   = carry_q;

endmodule

// File: tb/tb_alu_resp_collector.sv
// Directed and randomized bench for alu_resp_collector against a beat-level MISR reference model.
module tb_alu_resp_collector;

   localparam logic [15:0] SEED = 16'hFFFF;
   localparam int          TO   = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  num_beats = 8'd0;
   logic [15:0] exp_sig = 16'h0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_res = 8'd0;
   logic        in_carry = 1'b0;
   logic [3:0]  in_sel = 4'd0;
   logic        busy, done, pass, timeout_err;
   logic [15:0] signature;
   logic [7:0]  beat_cnt, carry_cnt;

   int checks = 0;
   int failures = 0;

   alu_resp_collector #(.SEED(SEED), .POLY(16'h1021), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .num_beats(num_beats), .exp_sig(exp_sig),
      .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_carry(in_carry),
      .in_sel(in_sel), .busy(busy), .done(done), .pass(pass), .timeout_err(timeout_err),
      .signature(signature), .beat_cnt(beat_cnt), .carry_cnt(carry_cnt)
   );

   always #5 clk = ~clk;

   // Reference: one MISR step using plain integer arithmetic.
   function automatic logic [15:0] m_step(input logic [15:0] s, input logic [7:0] r,
                                          input logic c, input logic [3:0] sl);
      int v;
      v = int'(s) * 2;
      if (v >= 65536) v = (v - 65536) ^ 32'h1021;
      v = v ^ (int'(sl) * 512 + int'(c) * 256 + int'(r));
      return v[15:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] n, input logic [15:0] e);
      start = 1'b1; num_beats = n; exp_sig = e;
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] r, input logic c, input logic [3:0] sl, input int gap);
      int w;
      in_valid = 1'b0;
      for (int i = 0; i < gap; i++) step();
      in_res = r; in_carry = c; in_sel = sl; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 20) begin step(); w++; end
      chk("ready_wait", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ready"}, {31'd0, in_ready}, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
      chk({tag, "_done"}, {31'd0, done}, 0);
      chk({tag, "_pass"}, {31'd0, pass}, 0);
      chk({tag, "_terr"}, {31'd0, timeout_err}, 0);
      chk({tag, "_sig"}, {16'd0, signature}, {16'd0, SEED});
      chk({tag, "_beat"}, {24'd0, beat_cnt}, 0);
      chk({tag, "_carry"}, {24'd0, carry_cnt}, 0);
   endtask

   task automatic rand_run(input int n, input bit match);
      logic [7:0]  r[$];
      logic        c[$];
      logic [3:0]  sl[$];
      logic [15:0] s, e;
      int          nc;
      s = SEED; nc = 0;
      for (int i = 0; i < n; i++) begin
         r.push_back(8'($urandom)); c.push_back(1'($urandom)); sl.push_back(4'($urandom));
         s = m_step(s, r[i], c[i], sl[i]);
         nc += int'(c[i]);
      end
      e = match ? s : s ^ 16'(1 + $urandom_range(0, 100));
      do_start(8'(n), e);
      for (int i = 0; i < n; i++) send(r[i], c[i], sl[i], int'($urandom_range(0, 4)));
      chk("rnd_done", {31'd0, done}, 1);
      chk("rnd_pass", {31'd0, pass}, {31'd0, match});
      chk("rnd_sig", {16'd0, signature}, {16'd0, s});
      chk("rnd_beat", {24'd0, beat_cnt}, n);
      chk("rnd_carry", {24'd0, carry_cnt}, nc);
      chk("rnd_terr", {31'd0, timeout_err}, 0);
   endtask

   initial begin
      logic [15:0] s;
      int cnt;

      // reset
      step(); step();
      rst = 1'b0;
      chk_reset_state("rst");

      // in_valid in IDLE is ignored
      in_valid = 1'b1; in_res = 8'h55; in_carry = 1'b1;
      step(); step(); step();
      in_valid = 1'b0;
      chk("idle_gate_beat", {24'd0, beat_cnt}, 0);
      chk("idle_gate_sig", {16'd0, signature}, {16'd0, SEED});

      // single beat known answer
      do_start(8'd1, 16'hEDD3);
      chk("one_busy", {31'd0, busy}, 1);
      send(8'h0C, 1'b0, 4'h1, 0);
      chk("one_sig", {16'd0, signature}, 32'hEDD3);
      chk("one_done", {31'd0, done}, 1);
      chk("one_pass", {31'd0, pass}, 1);
      chk("one_beat", {24'd0, beat_cnt}, 1);
      chk("one_carry", {24'd0, carry_cnt}, 0);

      // in_valid in DONE is ignored; outputs hold
      in_valid = 1'b1; in_res = 8'hA5; in_carry = 1'b1;
      step(); step(); step();
      in_valid = 1'b0;
      chk("done_gate_sig", {16'd0, signature}, 32'hEDD3);
      chk("done_gate_beat", {24'd0, beat_cnt}, 1);
      chk("done_gate_done", {31'd0, done}, 1);
      chk("done_gate_ready", {31'd0, in_ready}, 0);

      // mismatch with gapped beats and carry counting
      s = m_step(m_step(m_step(SEED, 8'h3C, 1'b1, 4'h2), 8'h81, 1'b0, 4'h7), 8'hF0, 1'b1, 4'hB);
      do_start(8'd3, 16'h0000);
      send(8'h3C, 1'b1, 4'h2, 0);
      send(8'h81, 1'b0, 4'h7, 2);
      send(8'hF0, 1'b1, 4'hB, 2);
      chk("mis_done", {31'd0, done}, 1);
      chk("mis_pass", {31'd0, pass}, {31'd0, (s == 16'h0000)});
      chk("mis_sig", {16'd0, signature}, {16'd0, s});
      chk("mis_beat", {24'd0, beat_cnt}, 3);
      chk("mis_carry", {24'd0, carry_cnt}, 2);

      // zero beats
      chk("zero_pre_ready", {31'd0, in_ready}, 0);
      do_start(8'd0, 16'hFFFF);
      chk("zero_done", {31'd0, done}, 1);
      chk("zero_pass", {31'd0, pass}, 1);
      chk("zero_ready", {31'd0, in_ready}, 0);
      chk("zero_beat", {24'd0, beat_cnt}, 0);

      // timeout: ERR exactly TIMEOUT cycles after entering COLLECT
      do_start(8'd4, 16'h1234);
      cnt = 0;
      while (!done && cnt < 40) begin step(); cnt++; end
      chk("to_cycles", cnt, TO);
      chk("to_terr", {31'd0, timeout_err}, 1);
      chk("to_pass", {31'd0, pass}, 0);
      chk("to_busy", {31'd0, busy}, 0);

      // accept on the expiry cycle beats the timeout
      s = m_step(m_step(SEED, 8'h11, 1'b0, 4'h3), 8'h22, 1'b1, 4'h4);
      do_start(8'd2, s);
      send(8'h11, 1'b0, 4'h3, TO - 1);
      chk("exp_busy", {31'd0, busy}, 1);
      chk("exp_terr", {31'd0, timeout_err}, 0);
      chk("exp_beat", {24'd0, beat_cnt}, 1);
      send(8'h22, 1'b1, 4'h4, TO - 1);
      chk("exp_done", {31'd0, done}, 1);
      chk("exp_pass", {31'd0, pass}, 1);
      chk("exp_terr2", {31'd0, timeout_err}, 0);

      // reset mid-run
      do_start(8'd5, 16'h0);
      send(8'h01, 1'b1, 4'h1, 0);
      send(8'h02, 1'b1, 4'h2, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset_state("midrst");
      step();
      chk("midrst_nodone", {31'd0, done}, 0);

      // restart mid-COLLECT; the beat offered with start is dropped
      do_start(8'd3, 16'h0);
      send(8'h77, 1'b1, 4'h9, 0);
      start = 1'b1; num_beats = 8'd1; exp_sig = 16'hEDD3;
      in_valid = 1'b1; in_res = 8'h99; in_carry = 1'b1; in_sel = 4'h5;
      step();
      start = 1'b0; in_valid = 1'b0;
      chk("rs_beat", {24'd0, beat_cnt}, 0);
      chk("rs_sig", {16'd0, signature}, {16'd0, SEED});
      chk("rs_carry", {24'd0, carry_cnt}, 0);
      chk("rs_busy", {31'd0, busy}, 1);
      send(8'h0C, 1'b0, 4'h1, 0);
      chk("rs_sig2", {16'd0, signature}, 32'hEDD3);
      chk("rs_pass", {31'd0, pass}, 1);

      // randomized runs
      for (int k = 0; k < 12; k++) rand_run(int'($urandom_range(1, 10)), bit'(k % 2));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
